// File: rtl/mem_copy_dma.sv
// Word-granular copy engine on the req/gnt/rvalid bus: reads len words from src, writes them to dst,
// one outstanding transaction at a time. All outputs are registered from the next state.
module mem_copy_dma #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    req_o,
  input  logic                    gnt_i,
  input  logic                    rvalid_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    we_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_src, w_src;
  logic [ADDR_WIDTH-1:0] r_dst, w_dst;
  logic [LEN_WIDTH-1:0]  r_len, w_len;
  logic [LEN_WIDTH-1:0]  r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_buf, w_buf;
  logic                  w_req_nxt;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_req;
  logic                  r_we;
  logic [BE_WIDTH-1:0]   r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  always_comb begin
    w_next = r_state;
    w_src  = r_src;
    w_dst  = r_dst;
    w_len  = r_len;
    w_cnt  = r_cnt;
    w_buf  = r_buf;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_src  = src_addr_i;
          w_dst  = dst_addr_i;
          w_len  = len_i;
          w_cnt  = '0;
          w_next = (len_i == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (gnt_i) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rvalid_i) begin
          w_buf  = rdata_i;
          w_next = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (gnt_i) w_next = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (rvalid_i) begin
          // pointers wrap modulo 2^ADDR_WIDTH by plain truncation
          w_src  = r_src + ADDR_ONE;
          w_dst  = r_dst + ADDR_ONE;
          w_cnt  = r_cnt + LEN_ONE;
          w_next = (w_cnt == r_len) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_req_nxt = (w_next == S_RD_REQ) || (w_next == S_WR_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_src   <= w_src;
      r_dst   <= w_dst;
      r_len   <= w_len;
      r_cnt   <= w_cnt;
      r_buf   <= w_buf;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_req   <= w_req_nxt;
      r_we    <= (w_next == S_WR_REQ);
      r_be    <= w_req_nxt ? '1 : '0;
      // address and write data hold their last value outside the request states
      if (w_next == S_RD_REQ) begin
        r_addr <= w_src;
      end else if (w_next == S_WR_REQ) begin
        r_addr  <= w_dst;
        r_wdata <= w_buf;
      end
    end
  end

  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign req_o   = r_req;
  assign we_o    = r_we;
  assign be_o    = r_be;
  assign addr_o  = r_addr;
  assign wdata_o = r_wdata;

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Word-granular memory copy engine acting as a bus initiator on the req/gnt/rvalid memory protocol. It occupies the spare requestor port (port 1) of a `ram_mux`, alongside the core on port 0. Once started, it reads `len_i` words from a source region and writes them to a destination region, one transaction at a time. Typical uses are program preload and buffer moves while the core runs.

## Interface
- `ADDR_WIDTH`, 10: word-address width of the memory port.
- `DATA_WIDTH`, 32: data width; byte-enable width is `DATA_WIDTH/8`.
- `LEN_WIDTH`, 11: width of the length and word counter; `ADDR_WIDTH+1`, so a full-memory copy fits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `src_addr_i`  in  ADDR_WIDTH  source word address; sampled with `start_i`.
- `dst_addr_i`  in  ADDR_WIDTH  destination word address; sampled with `start_i`.
- `len_i`  in  LEN_WIDTH  number of words to copy; sampled with `start_i`.
- `busy_o`  out  1  high from the cycle after start until the cycle `done_o` is high, inclusive.
- `done_o`  out  1  one-cycle completion pulse.
- `req_o`  out  1  transaction request.
- `gnt_i`  in  1  grant; a transaction is accepted on a rising edge where `req_o` and `gnt_i` are both high.
- `rvalid_i`  in  1  response valid, for reads and writes.
- `addr_o`  out  ADDR_WIDTH  word address.
- `we_o`  out  1  1 = write, 0 = read.
- `be_o`  out  DATA_WIDTH/8  byte enables; all ones during a request.
- `wdata_o`  out  DATA_WIDTH  write data.
- `rdata_i`  in  DATA_WIDTH  read data; valid with `rvalid_i`.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE. At most one outstanding transaction.
- IDLE, on `start_i`=1:
  - Latch `src_addr_i`, `dst_addr_i` and `len_i`; clear the word counter.
  - If `len_i`=0, go to DONE. Otherwise go to RD_REQ.
- RD_REQ: `req_o`=1, `we_o`=0, `addr_o`=src pointer. Hold all of these stable until granted. On `gnt_i`, go to RD_WAIT.
- RD_WAIT: `req_o`=0. On `rvalid_i`, capture `rdata_i` into the data buffer and go to WR_REQ.
- WR_REQ: `req_o`=1, `we_o`=1, `addr_o`=dst pointer, `wdata_o`=buffer. Hold all of these stable until granted. On `gnt_i`, go to WR_WAIT.
- WR_WAIT: on `rvalid_i`:
  - Increment both pointers and the counter.
  - If counter+1 equals len, go to DONE; else go to RD_REQ.
- DONE: `done_o`=1 for one cycle, then return to IDLE.
- Pointer arithmetic is modulo 2^ADDR_WIDTH: a pointer at the top address wraps to 0 silently.
- Copy order is ascending, word by word, read-before-write per word. Overlapping regions therefore have defined but non-memmove semantics: when dst>src and the regions overlap, the source data propagates forward.
- Ignored inputs:
  - `start_i` outside IDLE, including in DONE.
  - `gnt_i` while `req_o`=0.
  - `rvalid_i` outside RD_WAIT and WR_WAIT.
  - Changes to `src_addr_i`, `dst_addr_i` and `len_i` after they are sampled.

## Timing
- Reset values: `req_o`=0, `we_o`=0, `be_o`=0, `addr_o`=0, `wdata_o`=0, `busy_o`=0, `done_o`=0; state IDLE; pointers, counter and buffer 0.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Outside RD_REQ and WR_REQ, `be_o`=0 and `req_o`=0.
- `req_o` rises in the cycle after the state is entered. It falls in the cycle after the accepting edge.
- Per-word latency with `gnt_i` tied high and `rvalid_i` one cycle after grant: 4 cycles.
- For `len_i`=N>0 under those conditions:
  - `busy_o` rises 1 cycle after the start edge.
  - `done_o` is high exactly 4N cycles after `busy_o` rises.
- `len_i`=0: no request is issued; `done_o` is high 1 cycle after the start edge; `busy_o` is high in that same cycle.
- Each cycle of `gnt_i` low adds one cycle; each extra cycle of `rvalid_i` delay adds one cycle.
- Reset asserted mid-transfer:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - The in-flight transaction is abandoned; no `done_o` pulse.
  - A later `rvalid_i` is ignored in IDLE.

## Test plan
- Basic copy: preload src 0x010..0x013 = {A0,A1,A2,A3}; start with src=0x010, dst=0x100, len=4; `gnt_i`=1, rvalid 1 cycle after grant. Required: 4 reads then 4 writes interleaved (R,W,R,W...); dst 0x100..0x103 = {A0..A3}; `done_o` exactly 16 cycles after `busy_o` rises.
- Zero length: start with len=0. Required: `req_o` never asserted; `done_o` pulse 1 cycle after the start edge; `busy_o` high for that single cycle.
- Backpressure: random `gnt_i` stalls of 0-5 cycles and rvalid delays of 1-3 cycles. Required: `addr_o`, `we_o` and `wdata_o` stable while `req_o` is high and ungranted; data copied correctly; exactly one transaction per grant.
- Wrap-around: src=0x3FE, dst=0x001, len=4. Required: reads at 0x3FE, 0x3FF, 0x000, 0x001; writes at 0x001..0x004; dst ends with the source values as read in ascending order, so overlapping words propagate forward.
- Restart and ignore: pulse `start_i` while busy, and inject a spurious `rvalid_i` in RD_REQ. Required: both ignored and the transfer completes unchanged. A new start after `done_o` runs normally.
- Reset mid-transfer: assert `rst_n`=0 in WR_REQ of word 2 of 4. Required: `req_o`, `busy_o` and `done_o` drop asynchronously; no `done_o` ever pulses. A fresh len=1 copy after release completes in 4 cycles.
